// File: rtl/sensor_capture_fifo.sv
// sensor_capture_fifo: captures NUM_CH x DATA_W sensor frames (snapshot or decimated stream) into a DEPTH-frame FIFO drained over valid/ready
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   sensor_in     : packed samples, channel k at [k*DATA_W +: DATA_W]
//   sensor_en     : capture enable (level)
//   sensor_mode   : 0 = snapshot on enable rising edge, 1 = stream
//   sensor_decim  : stream mode captures every sensor_decim+1 cycles
//   out_data      : FIFO head frame (0 when empty)
//   out_valid     : head frame valid
//   out_ready     : consumer accepts head when out_valid=1
//   fifo_count    : frames stored
//   overflow      : sticky frame-dropped flag
//   clr_overflow  : clears overflow (a same-cycle drop wins)
module sensor_capture_fifo #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int DECIM_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*DATA_W-1:0]    sensor_in,
    input  logic                        sensor_en,
    input  logic                        sensor_mode,
    input  logic [DECIM_W-1:0]          sensor_decim,
    output logic [NUM_CH*DATA_W-1:0]    out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
    output logic                        overflow,
    input  logic                        clr_overflow
);
    localparam int FW = NUM_CH * DATA_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [FW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [DECIM_W-1:0] dcnt_q, dcnt_d, decim_q, decim_d, lim;
    logic               en_q, overflow_q, overflow_d;
    logic               cap, push, pop, full;

    always_comb begin
        cap        = sensor_mode ? (sensor_en && dcnt_q == '0) : (sensor_en && !en_q);
        // decim is sampled at the start of each period so a change only applies after the wrap
        lim        = (dcnt_q == '0) ? sensor_decim : decim_q;
        decim_d    = lim;
        dcnt_d     = (!sensor_en || !sensor_mode || dcnt_q == lim) ? '0 : dcnt_q + DECIM_W'(1);
        full       = count_q == CW'(DEPTH);
        pop        = (count_q != '0) && out_ready;
        // a full FIFO still accepts a push when the head leaves in the same cycle
        push       = cap && (!full || pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = (cap && full && !pop) || (overflow_q && !clr_overflow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dcnt_q     <= '0;
            decim_q    <= '0;
            en_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dcnt_q     <= dcnt_d;
            decim_q    <= decim_d;
            en_q       <= sensor_en;
            overflow_q <= overflow_d;
        end
    end

    // storage needs no reset: out_data is gated by the count
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= sensor_in;
    end

    assign out_valid  = count_q != '0;
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_sensor_capture_fifo.sv
// tb_sensor_capture_fifo: directed self-checking bench for sensor_capture_fifo
module tb_sensor_capture_fifo;
    logic        clk = 1'b0;
    logic        rst, sensor_en, sensor_mode, out_ready, clr_overflow;
    logic [31:0] sensor_in, out_data;
    logic [7:0]  sensor_decim;
    logic        out_valid, overflow;
    logic [3:0]  fifo_count;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] q[$];

    sensor_capture_fifo dut (
        .clk(clk), .rst(rst), .sensor_in(sensor_in), .sensor_en(sensor_en),
        .sensor_mode(sensor_mode), .sensor_decim(sensor_decim), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] data, input int cnt, input logic ovf);
        chk({tag, "_data"}, out_data, data);
        chk({tag, "_valid"}, 32'(out_valid), 32'(cnt != 0));
        chk({tag, "_count"}, 32'(fifo_count), 32'(cnt));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        rst = 1; sensor_en = 0; sensor_mode = 0; sensor_decim = 0;
        out_ready = 0; clr_overflow = 0; sensor_in = 0;
        tick(); tick();
        rst = 0;
        chk_state("reset", 0, 0, 0);

        // 1: snapshot, enable held 5 cycles -> one frame
        sensor_in = 32'h44332211; sensor_en = 1;
        chk("snap_pre_valid", 32'(out_valid), 0);
        tick();
        chk_state("snap", 32'h44332211, 1, 0);
        for (int i = 0; i < 4; i++) tick();
        chk_state("snap_hold", 32'h44332211, 1, 0);
        sensor_en = 0; out_ready = 1;
        tick();
        out_ready = 0;
        chk_state("snap_pop", 0, 0, 0);

        // 2: stream decim=2, 9 enabled cycles -> captures at 0,3,6
        sensor_mode = 1; sensor_decim = 2;
        for (int i = 0; i < 9; i++) begin
            sensor_in = 32'h1000 + 32'(i); sensor_en = 1;
            tick();
            chk("dec2_count", 32'(fifo_count), 32'(i / 3 + 1));
        end
        sensor_en = 0;
        chk("dec2_head", out_data, 32'h1000);
        out_ready = 1;
        chk("dec2_pop0", out_data, 32'h1000); tick();
        chk("dec2_pop1", out_data, 32'h1003); tick();
        chk("dec2_pop2", out_data, 32'h1006); tick();
        out_ready = 0;
        chk_state("dec2_empty", 0, 0, 0);

        // 3: decim=0, 10 cycles with no reader -> saturate at 8, overflow
        sensor_decim = 0;
        for (int i = 0; i < 10; i++) begin
            sensor_in = 32'h2000 + 32'(i); sensor_en = 1;
            tick();
            chk("sat_count", 32'(fifo_count), 32'(i < 8 ? i + 1 : 8));
            chk("sat_ovf", 32'(overflow), 32'(i >= 8));
        end
        sensor_en = 0;
        tick();
        chk_state("sat_hold", 32'h2000, 8, 1);
        clr_overflow = 1;
        tick();
        clr_overflow = 0;
        chk_state("clr_ovf", 32'h2000, 8, 0);

        // 4: full, capture with pop in same cycle -> no drop
        sensor_in = 32'h3000; sensor_en = 1; out_ready = 1;
        tick();
        sensor_en = 0; out_ready = 0;
        chk_state("full_pushpop", 32'h2001, 8, 0);
        out_ready = 1;
        for (int i = 1; i < 8; i++) begin
            chk("drain", out_data, 32'h2000 + 32'(i));
            tick();
        end
        chk("drain_last", out_data, 32'h3000);
        tick();
        out_ready = 0;
        chk_state("drain_empty", 0, 0, 0);

        // 5: reset with 3 frames queued while streaming
        sensor_in = 32'h5000; sensor_en = 1;
        tick(); tick(); tick();
        chk("pre_rst_count", 32'(fifo_count), 3);
        rst = 1;
        tick();
        rst = 0; sensor_en = 0;
        chk_state("mid_rst", 0, 0, 0);
        tick();
        chk_state("post_rst", 0, 0, 0);

        // 6: decim=1 stream with out_ready toggling every cycle
        sensor_decim = 1;
        for (int i = 0; i < 14; i++) begin
            chk("bp_count", 32'(fifo_count), 32'(q.size()));
            if (q.size() != 0) chk("bp_data", out_data, q[0]);
            sensor_en = i < 12;
            sensor_in = 32'h4000 + 32'(i);
            out_ready = i[0];
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (i < 12 && i % 2 == 0) q.push_back(32'h4000 + 32'(i));
            tick();
        end
        sensor_en = 0; out_ready = 1;
        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            chk("bp_drain", out_data, q[0]);
            void'(q.pop_front());
            tick();
        end
        chk("bp_drain_done", 32'(q.size()), 0);
        chk_state("bp_end", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
